switch_box_config_loader: RTL and testbench

//  Upstream feeder of the switch box's config_in bus. Accepts the tile bitstream as a valid/ready word

---
 rtl/config_pkg.sv | 24 ++
 rtl/config_fwd_buffer.sv | 67 ++++++
 rtl/switch_box_config_loader.sv | 175 +++++++++++++++++
 tb/tb_switch_box_config_loader.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/config_pkg.sv
// ============================================================================
//  Module      : config_pkg
//  Description : Shared state encoding and sizing helpers for the config loader.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package config_pkg;

    localparam int SB_CONFIG_WIDTH = 264;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        FORWARD = 2'd2
    } state_t;

    function automatic int config_words(input int cw, input int ww);
        return (cw + ww - 1) / ww;
    endfunction

endpackage

`default_nettype wire

// File: rtl/config_fwd_buffer.sv
// ============================================================================
//  Module      : config_fwd_buffer
//  Description : One-entry valid/ready register carrying words to the next tile.
//                Optional parity lane when CONFIG_PARITY_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module config_fwd_buffer #(
    parameter int WORD_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_push,
    input  logic [WORD_WIDTH-1:0] i_data,
    input  logic                  i_last,
`ifdef CONFIG_PARITY_EN
    input  logic                  i_parity,
    output logic                  o_parity,
`endif
    output logic                  o_ready,
    output logic                  o_valid,
    output logic [WORD_WIDTH-1:0] o_data,
    output logic                  o_last,
    input  logic                  i_ready
);

    logic                  r_valid;
    logic [WORD_WIDTH-1:0] r_data;
    logic                  r_last;

    // Space exists when empty or when the held word leaves this cycle.
    assign o_ready = !r_valid | i_ready;
    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_last  = r_last;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_last  <= 1'b0;
        end else if (i_push) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
            r_last  <= i_last;
        end else if (i_ready) begin
            r_valid <= 1'b0;
        end
    end

`ifdef CONFIG_PARITY_EN
    logic r_parity;
    assign o_parity = r_parity;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_parity <= 1'b0;
        end else if (i_push) begin
            r_parity <= i_parity;
        end
    end
`endif

endmodule

`default_nettype wire

// File: rtl/switch_box_config_loader.sv
// ============================================================================
//  Module      : switch_box_config_loader
//  Description : Loads this tile's share of the bitstream, forwards the rest,
//                commits atomically on the frame's last word.
//                Optional word parity checking with CONFIG_PARITY_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module switch_box_config_loader
    import config_pkg::*;
#(
    parameter int CONFIG_WIDTH = SB_CONFIG_WIDTH,
    parameter int WORD_WIDTH   = 8
) (
    input  logic                    clock,
    input  logic                    nreset,
    input  logic                    cfg_valid_in,
    output logic                    cfg_ready_out,
    input  logic [WORD_WIDTH-1:0]   cfg_data_in,
    input  logic                    cfg_last_in,
`ifdef CONFIG_PARITY_EN
    input  logic                    cfg_parity_in,
    output logic                    cfg_parity_out,
`endif
    output logic                    cfg_valid_out,
    input  logic                    cfg_ready_in,
    output logic [WORD_WIDTH-1:0]   cfg_data_out,
    output logic                    cfg_last_out,
    output logic [CONFIG_WIDTH-1:0] config_out,
    output logic                    config_done,
    output logic                    config_error
);

    localparam int               WORDS    = config_words(CONFIG_WIDTH, WORD_WIDTH);
    localparam int               SHIFT_W  = WORDS * WORD_WIDTH;
    localparam int               CNT_W    = $clog2(WORDS + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WORDS - 1);

    state_t                  r_state, w_state_next;
    logic [CNT_W-1:0]        r_count, w_count_next;
    logic [SHIFT_W-1:0]      r_shift, w_shift_next;
    logic [CONFIG_WIDTH-1:0] r_config;
    logic                    r_done;
    logic                    r_error;
    logic                    w_accept;
    logic                    w_push;
    logic                    w_commit;
    logic                    w_short;
    logic                    w_new_frame;
    logic                    w_buf_ready;
    logic                    w_par_err_next;

    always_comb begin
        w_state_next  = r_state;
        w_count_next  = r_count;
        w_shift_next  = r_shift;
        w_push        = 1'b0;
        w_commit      = 1'b0;
        w_short       = 1'b0;
        w_new_frame   = 1'b0;
        cfg_ready_out = (r_state == FORWARD) ? w_buf_ready : 1'b1;
        w_accept      = cfg_valid_in & cfg_ready_out;

        unique case (r_state)
            IDLE, LOAD: begin
                if (w_accept) begin
                    w_new_frame = (r_state == IDLE);
                    w_shift_next[r_count*WORD_WIDTH +: WORD_WIDTH] = cfg_data_in;
                    if (cfg_last_in) begin
                        w_state_next = IDLE;
                        w_count_next = '0;
                        w_commit     = (r_count == LAST_IDX);
                        w_short      = (r_count != LAST_IDX);
                    end else if (r_count == LAST_IDX) begin
                        w_state_next = FORWARD;
                    end else begin
                        w_state_next = LOAD;
                        w_count_next = r_count + 1'b1;
                    end
                end
            end
            FORWARD: begin
                if (w_accept) begin
                    w_push = 1'b1;
                    if (cfg_last_in) begin
                        w_state_next = IDLE;
                        w_count_next = '0;
                        w_commit     = 1'b1;
                    end
                end
            end
            default: begin
                w_state_next = IDLE;
                w_count_next = '0;
            end
        endcase
    end

`ifdef CONFIG_PARITY_EN
    logic r_par_err;
    logic w_word_par_err;

    // Even parity: the data bits plus the parity bit must XOR to zero.
    assign w_word_par_err = (^cfg_data_in) ^ cfg_parity_in;

    always_comb begin
        w_par_err_next = r_par_err;
        if (w_accept && (r_state != FORWARD)) begin
            w_par_err_next = (w_new_frame ? 1'b0 : r_par_err) | w_word_par_err;
        end
    end

    always_ff @(posedge clock) begin
        if (!nreset) begin
            r_par_err <= 1'b0;
        end else begin
            r_par_err <= w_par_err_next;
        end
    end
`else
    assign w_par_err_next = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (!nreset) begin
            r_state  <= IDLE;
            r_count  <= '0;
            r_shift  <= '0;
            r_config <= '0;
            r_done   <= 1'b0;
            r_error  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_count <= w_count_next;
            r_shift <= w_shift_next;
            if (w_commit && !w_par_err_next) begin
                r_config <= w_shift_next[CONFIG_WIDTH-1:0];
                r_done   <= 1'b1;
            end
            // Error wins over the clear when a one-word frame is also short.
            if (w_short || (w_commit && w_par_err_next)) begin
                r_error <= 1'b1;
            end else if (w_new_frame) begin
                r_error <= 1'b0;
            end
        end
    end

    config_fwd_buffer #(
        .WORD_WIDTH (WORD_WIDTH)
    ) u_fwd_buffer (
        .clk      (clock),
        .rst_n    (nreset),
        .i_push   (w_push),
        .i_data   (cfg_data_in),
        .i_last   (cfg_last_in),
`ifdef CONFIG_PARITY_EN
        .i_parity (cfg_parity_in),
        .o_parity (cfg_parity_out),
`endif
        .o_ready  (w_buf_ready),
        .o_valid  (cfg_valid_out),
        .o_data   (cfg_data_out),
        .o_last   (cfg_last_out),
        .i_ready  (cfg_ready_in)
    );

    assign config_out   = r_config;
    assign config_done  = r_done;
    assign config_error = r_error;

endmodule

`default_nettype wire

// File: tb/tb_switch_box_config_loader.sv
// ============================================================================
//  Module      : tb_switch_box_config_loader
//  Description : Self-checking bench for switch_box_config_loader against a
//                frame-level reference model (parity case with CONFIG_PARITY_EN).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_switch_box_config_loader;

    localparam int CW    = 264;
    localparam int WW    = 8;
    localparam int WORDS = 33;

    logic          clock;
    logic          nreset;
    logic          cfg_valid_in;
    logic          cfg_ready_out;
    logic [WW-1:0] cfg_data_in;
    logic          cfg_last_in;
    logic          cfg_valid_out;
    logic          cfg_ready_in;
    logic [WW-1:0] cfg_data_out;
    logic          cfg_last_out;
    logic [CW-1:0] config_out;
    logic          config_done;
    logic          config_error;
`ifdef CONFIG_PARITY_EN
    logic          cfg_parity_in;
    logic          cfg_parity_out;
`endif

    switch_box_config_loader #(
        .CONFIG_WIDTH (CW),
        .WORD_WIDTH   (WW)
    ) dut (
        .clock         (clock),
        .nreset        (nreset),
        .cfg_valid_in  (cfg_valid_in),
        .cfg_ready_out (cfg_ready_out),
        .cfg_data_in   (cfg_data_in),
        .cfg_last_in   (cfg_last_in),
`ifdef CONFIG_PARITY_EN
        .cfg_parity_in (cfg_parity_in),
        .cfg_parity_out(cfg_parity_out),
`endif
        .cfg_valid_out (cfg_valid_out),
        .cfg_ready_in  (cfg_ready_in),
        .cfg_data_out  (cfg_data_out),
        .cfg_last_out  (cfg_last_out),
        .config_out    (config_out),
        .config_done   (config_done),
        .config_error  (config_error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int            checks = 0;
    int            errors = 0;
    logic [CW-1:0] exp_cfg;
    logic          exp_done;
    logic          exp_err;
    logic [8:0]    fwd_q[$];
    logic [8:0]    exp_fwd[$];
    bit            rand_ds;
    bit            rand_gap;

    // Downstream observer: records every word handed to the next tile.
    always @(negedge clock) begin
        if (nreset && cfg_valid_out && cfg_ready_in) fwd_q.push_back({cfg_last_out, cfg_data_out});
    end

    task automatic chk(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Entered and left at posedge+1; acceptance decided by ready seen at negedge.
    task automatic send_word(input logic [7:0] d, input logic l, input bit par_ok);
        bit got;
        if (rand_gap) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clock); #1;
                if (rand_ds) cfg_ready_in = 1'($urandom_range(0, 1));
            end
        end
        cfg_valid_in = 1'b1;
        cfg_data_in  = d;
        cfg_last_in  = l;
`ifdef CONFIG_PARITY_EN
        cfg_parity_in = (^d) ^ !par_ok;
`endif
        got = 1'b0;
        for (int t = 0; t < 200 && !got; t++) begin
            @(negedge clock);
            got = cfg_ready_out;
            @(posedge clock); #1;
            if (rand_ds) cfg_ready_in = 1'($urandom_range(0, 1));
        end
        cfg_valid_in = 1'b0;
        cfg_last_in  = 1'b0;
        chk("word_accepted", CW'(got), CW'(1));
    endtask

    // Frame-level rules: first WORDS words form the config, the rest go downstream.
    task automatic model_frame(input logic [7:0] w[], input int n, input int bad_par);
        exp_fwd.delete();
        if (n < WORDS || (bad_par >= 0 && bad_par < WORDS)) begin
            exp_err = 1'b1;
        end else begin
            for (int i = 0; i < WORDS; i++) exp_cfg[i*8 +: 8] = w[i];
            exp_done = 1'b1;
            exp_err  = 1'b0;
        end
        for (int i = WORDS; i < n; i++) exp_fwd.push_back({(i == n - 1) ? 1'b1 : 1'b0, w[i]});
    endtask

    task automatic finish_frame();
        cfg_ready_in = 1'b1;
        @(negedge clock);
        chk("done_after_last", CW'(config_done), CW'(exp_done));
        repeat (3) @(negedge clock);
        chk("config_out", config_out, exp_cfg);
        chk("config_error", CW'(config_error), CW'(exp_err));
        chk("fwd_idle", CW'(cfg_valid_out), CW'(0));
        chk("fwd_count", CW'(fwd_q.size()), CW'(exp_fwd.size()));
        for (int i = 0; i < exp_fwd.size() && i < fwd_q.size(); i++)
            chk("fwd_word", CW'(fwd_q[i]), CW'(exp_fwd[i]));
        @(posedge clock); #1;
    endtask

    task automatic run_frame(input int n, input bit rnd, input int bad_par);
        logic [7:0] w[];
        w = new[n];
        fwd_q.delete();
        for (int i = 0; i < n; i++) w[i] = rnd ? 8'($urandom) : 8'(i);
        for (int i = 0; i < n; i++) send_word(w[i], (i == n - 1), (i != bad_par));
        model_frame(w, n, bad_par);
        finish_frame();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: observed=running expected=finished");
        $fatal(1);
    end

    initial begin
        logic [7:0] w3[];
        bit         got;
        nreset       = 1'b0;
        cfg_valid_in = 1'b0;
        cfg_data_in  = '0;
        cfg_last_in  = 1'b0;
        cfg_ready_in = 1'b1;
`ifdef CONFIG_PARITY_EN
        cfg_parity_in = 1'b0;
`endif
        rand_ds  = 1'b0;
        rand_gap = 1'b0;
        exp_cfg  = '0;
        exp_done = 1'b0;
        exp_err  = 1'b0;
        repeat (3) @(posedge clock);
        #1 nreset = 1'b1;

        // Reset state
        @(negedge clock);
        chk("rst_config_out", config_out, '0);
        chk("rst_done", CW'(config_done), CW'(0));
        chk("rst_error", CW'(config_error), CW'(0));
        chk("rst_valid_out", CW'(cfg_valid_out), CW'(0));
        chk("rst_data_out", CW'(cfg_data_out), CW'(0));
        chk("rst_ready_out", CW'(cfg_ready_out), CW'(1));
        @(posedge clock); #1;

        // Exact-share frame
        run_frame(33, 1'b0, -1);
        chk("t1_low_byte", CW'(config_out[7:0]), CW'(8'h00));
        chk("t1_high_byte", CW'(config_out[263:256]), CW'(8'h20));

        // Two words forwarded
        run_frame(35, 1'b0, -1);

        // Downstream stall with buffer full
        fwd_q.delete();
        w3 = new[35];
        for (int i = 0; i < 35; i++) w3[i] = 8'(i);
        for (int i = 0; i < 33; i++) send_word(w3[i], 1'b0, 1'b1);
        cfg_ready_in = 1'b0;
        send_word(w3[33], 1'b0, 1'b1);
        cfg_valid_in = 1'b1;
        cfg_data_in  = w3[34];
        cfg_last_in  = 1'b1;
`ifdef CONFIG_PARITY_EN
        cfg_parity_in = ^w3[34];
`endif
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            chk("stall_ready_out", CW'(cfg_ready_out), CW'(0));
            chk("stall_valid_out", CW'(cfg_valid_out), CW'(1));
            chk("stall_data_out", CW'(cfg_data_out), CW'(8'h21));
            @(posedge clock); #1;
        end
        cfg_ready_in = 1'b1;
        got = 1'b0;
        for (int t = 0; t < 20 && !got; t++) begin
            @(negedge clock);
            got = cfg_ready_out;
            @(posedge clock); #1;
        end
        cfg_valid_in = 1'b0;
        cfg_last_in  = 1'b0;
        chk("stall_release_accept", CW'(got), CW'(1));
        model_frame(w3, 35, -1);
        finish_frame();

        // Short frame, then recovery
        run_frame(11, 1'b1, -1);
        run_frame(33, 1'b1, -1);

        // Reset in the middle of a frame
        fwd_q.delete();
        for (int i = 0; i < 20; i++) send_word(8'($urandom), 1'b0, 1'b1);
        nreset = 1'b0;
        @(posedge clock);
        @(negedge clock);
        chk("midrst_config_out", config_out, '0);
        chk("midrst_done", CW'(config_done), CW'(0));
        chk("midrst_error", CW'(config_error), CW'(0));
        chk("midrst_valid_out", CW'(cfg_valid_out), CW'(0));
        chk("midrst_last_out", CW'(cfg_last_out), CW'(0));
        @(posedge clock); #1;
        nreset   = 1'b1;
        exp_cfg  = '0;
        exp_done = 1'b0;
        exp_err  = 1'b0;
        run_frame(33, 1'b1, -1);

`ifdef CONFIG_PARITY_EN
        run_frame(33, 1'b1, 5);
        run_frame(33, 1'b1, -1);
`endif

        // Randomized frames with gaps and downstream back-pressure
        rand_ds  = 1'b1;
        rand_gap = 1'b1;
        for (int f = 0; f < 20; f++) begin
            int n;
            int bad;
            n   = $urandom_range(8, 40);
            bad = -1;
`ifdef CONFIG_PARITY_EN
            if ($urandom_range(0, 3) == 0) bad = $urandom_range(0, n - 1);
`endif
            run_frame(n, 1'b1, bad);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
